// File: rtl/vend_ctrl_param_if.sv
// Keypad and display/dispense bundle for vend_ctrl_param.
// Handshake: there is no backpressure in either direction. The keypad side
// presents raw active-low c/r lines; the controller presents change_amount
// qualified by change_valid (level, held until the customer takes it),
// vend_id qualified by the one-cycle vend_pulse, and coin_reject as a
// standalone one-cycle strobe. All controller outputs are registered.
interface vend_ctrl_param_if #(
    parameter int N_PROD  = 5,
    parameter int PRICE_W = 8,
    parameter int QTY_W   = 4,
    parameter int AMT_W   = 13
);
    logic [3:0]               c;
    logic [3:0]               r;
    logic [N_PROD*PRICE_W-1:0] price_table;
    logic [PRICE_W-1:0]       view_price;
    logic [QTY_W-1:0]         view_quantity;
    logic [AMT_W-1:0]         view_price_q;
    logic [AMT_W-1:0]         entered_amount;
    logic [AMT_W-1:0]         change_amount;
    logic                     change_valid;
    logic                     vend_pulse;
    logic [2:0]               vend_id;
    logic                     coin_reject;
    logic [2:0]               state_o;

    modport master (
        output c, r, price_table,
        input  view_price, view_quantity, view_price_q, entered_amount,
               change_amount, change_valid, vend_pulse, vend_id,
               coin_reject, state_o
    );

    modport slave (
        input  c, r, price_table,
        output view_price, view_quantity, view_price_q, entered_amount,
               change_amount, change_valid, vend_pulse, vend_id,
               coin_reject, state_o
    );
endinterface

// File: rtl/vend_ctrl_param.sv
// Parametrised keypad vending controller.
// Decodes a synchronised 4x4 active-low keypad into single key events and
// runs the select / quantity / confirm / pay / vend / done flow with
// per-product stock, an inactivity timeout and change/refund output.
// Optional feature macro VEND_CHANGE_EN: when defined any coin is accepted
// in PAY and overpayment is returned as change; when undefined a coin that
// would overshoot the total is refused with a coin_reject strobe.
module vend_ctrl_param #(
    parameter int N_PROD     = 5,
    parameter int PRICE_W    = 8,
    parameter int QTY_W      = 4,
    parameter int AMT_W      = 13,
    parameter int STOCK_INIT = 5,
    parameter int TIMEOUT    = 1000
) (
    input  logic             clk,
    input  logic             reset,
    vend_ctrl_param_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int MW = PRICE_W + QTY_W;

    if (N_PROD < 1 || N_PROD > 8) begin : g_bad_nprod
        $error("vend_ctrl_param: N_PROD must be 1..8");
    end
    if (AMT_W < PRICE_W + QTY_W + 1) begin : g_bad_amtw
        $error("vend_ctrl_param: AMT_W too narrow for price*qty");
    end
    if (STOCK_INIT > (2 ** QTY_W) - 1) begin : g_bad_stock
        $error("vend_ctrl_param: STOCK_INIT exceeds quantity range");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("vend_ctrl_param: TIMEOUT must be at least 2");
    end

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SELECT  = 3'd1,
        S_QTY     = 3'd2,
        S_CONFIRM = 3'd3,
        S_PAY     = 3'd4,
        S_VEND    = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    // Returns {valid, index} when exactly one active-low line is asserted.
    function automatic logic [2:0] one_low(input logic [3:0] v);
        logic [2:0] res;
        res = 3'b000;
        case (v)
            4'b1110: res = 3'b100;
            4'b1101: res = 3'b101;
            4'b1011: res = 3'b110;
            4'b0111: res = 3'b111;
            default: res = 3'b000;
        endcase
        return res;
    endfunction

    logic [3:0] c_s1, c_s2, r_s1, r_s2;
    logic       key_prev, key_now, key_ev;
    logic [2:0] c_dec, r_dec;
    logic [3:0] key_idx;

    state_t             state_q, state_d;
    logic [2:0]         prod_q, prod_d;
    logic [PRICE_W-1:0] price_q, price_d;
    logic [QTY_W-1:0]   qty_q, qty_d;
    logic [AMT_W-1:0]   total_q, total_d;
    logic [AMT_W-1:0]   entered_q, entered_d;
    logic [AMT_W-1:0]   change_q, change_d;
    logic               chv_q, chv_d;
    logic               vend_q, vend_d;
    logic [2:0]         vid_q, vid_d;
    logic               rej_q, rej_d;
    logic [QTY_W-1:0]   stock_q [0:7];
    logic [QTY_W-1:0]   stock_d [0:7];
    logic [TW-1:0]      timer_q, timer_d;

    logic [PRICE_W-1:0] price_arr [0:7];
    logic [MW-1:0]      mult;
    logic [AMT_W-1:0]   coin_val, sum;
    logic               coin_ok, prod_key, counting, expire;

    // Unused product slots read as price 0 so indexing stays 3 bits wide.
    for (genvar g = 0; g < 8; g++) begin : g_price
        if (g < N_PROD) begin : g_used
            assign price_arr[g] = bus.price_table[g*PRICE_W +: PRICE_W];
        end else begin : g_unused
            assign price_arr[g] = '0;
        end
    end

    assign mult = {{QTY_W{1'b0}}, price_q} * {{PRICE_W{1'b0}}, qty_q};
    assign sum  = entered_q + coin_val;

    // Two-flop synchroniser for the keypad lines plus key-down history.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c_s1     <= 4'hF;
            c_s2     <= 4'hF;
            r_s1     <= 4'hF;
            r_s2     <= 4'hF;
            key_prev <= 1'b0;
        end else begin
            c_s1     <= bus.c;
            c_s2     <= c_s1;
            r_s1     <= bus.r;
            r_s2     <= r_s1;
            key_prev <= key_now;
        end
    end

    // Decode one key and classify it; an event fires only on key-down.
    always_comb begin
        c_dec    = one_low(c_s2);
        r_dec    = one_low(r_s2);
        key_now  = c_dec[2] & r_dec[2];
        key_idx  = {c_dec[1:0], r_dec[1:0]};
        key_ev   = key_now & ~key_prev;
        prod_key = key_ev && (key_idx < 4'(N_PROD));
        coin_ok  = 1'b0;
        coin_val = '0;
        if (key_ev) begin
            case (key_idx)
                4'd12:   begin coin_ok = 1'b1; coin_val = AMT_W'(2);  end
                4'd13:   begin coin_ok = 1'b1; coin_val = AMT_W'(5);  end
                4'd14:   begin coin_ok = 1'b1; coin_val = AMT_W'(10); end
                default: begin coin_ok = 1'b0; coin_val = '0;         end
            endcase
        end
        counting = (state_q >= S_SELECT) && (state_q <= S_PAY);
        expire   = counting && !key_ev && (timer_q == TW'(TIMEOUT - 1));
    end

    // Next-state and next-output logic; timeout behaves like cancel in PAY.
    always_comb begin
        state_d   = state_q;
        prod_d    = prod_q;
        price_d   = price_q;
        qty_d     = qty_q;
        total_d   = total_q;
        entered_d = entered_q;
        change_d  = change_q;
        chv_d     = chv_q;
        vend_d    = 1'b0;
        vid_d     = vid_q;
        rej_d     = 1'b0;
        stock_d   = stock_q;
        if (expire) begin
            if (entered_q != '0) begin
                state_d  = S_DONE;
                change_d = entered_q;
                chv_d    = 1'b1;
            end else begin
                state_d = S_IDLE;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    entered_d = '0;
                    change_d  = '0;
                    chv_d     = 1'b0;
                    price_d   = '0;
                    qty_d     = '0;
                    total_d   = '0;
                    if (key_ev && key_idx == 4'd15) state_d = S_SELECT;
                end
                S_SELECT: begin
                    if (prod_key && stock_q[key_idx[2:0]] != '0) begin
                        state_d = S_QTY;
                        prod_d  = key_idx[2:0];
                        price_d = price_arr[key_idx[2:0]];
                        qty_d   = QTY_W'(1);
                    end else if (key_ev && key_idx == 4'd11) begin
                        state_d = S_IDLE;
                    end
                end
                S_QTY: begin
                    if (key_ev) begin
                        case (key_idx)
                            4'd8:  if (qty_q < stock_q[prod_q]) qty_d = qty_q + QTY_W'(1);
                            4'd9:  if (qty_q > QTY_W'(1)) qty_d = qty_q - QTY_W'(1);
                            4'd10: begin
                                state_d = S_CONFIRM;
                                total_d = {{(AMT_W-MW){1'b0}}, mult};
                            end
                            4'd11: state_d = S_SELECT;
                            default: ;
                        endcase
                    end
                end
                S_CONFIRM: begin
                    if (key_ev && key_idx == 4'd10) state_d = S_PAY;
                    else if (key_ev && key_idx == 4'd11) state_d = S_QTY;
                end
                S_PAY: begin
                    if (entered_q >= total_q) begin
                        state_d = S_VEND;
                        vend_d  = 1'b1;
                        vid_d   = prod_q;
                    end else if (coin_ok) begin
`ifdef VEND_CHANGE_EN
                        entered_d = sum;
`else
                        if (sum <= total_q) entered_d = sum;
                        else rej_d = 1'b1;
`endif
                    end else if (key_ev && key_idx == 4'd11) begin
                        if (entered_q != '0) begin
                            state_d  = S_DONE;
                            change_d = entered_q;
                            chv_d    = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                S_VEND: begin
                    stock_d[prod_q] = stock_q[prod_q] - qty_q;
`ifdef VEND_CHANGE_EN
                    change_d = entered_q - total_q;
                    chv_d    = (entered_q != total_q);
`else
                    change_d = '0;
                    chv_d    = 1'b0;
`endif
                    state_d = S_DONE;
                end
                S_DONE: begin
                    if (key_ev && key_idx == 4'd15) begin
                        state_d  = S_IDLE;
                        change_d = '0;
                        chv_d    = 1'b0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Inactivity timer restarts on any key event or state change.
    always_comb begin
        if (key_ev || (state_d != state_q) || !counting) timer_d = '0;
        else timer_d = timer_q + TW'(1);
    end

    // State and output registers; reset discards any coins held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            prod_q    <= '0;
            price_q   <= '0;
            qty_q     <= '0;
            total_q   <= '0;
            entered_q <= '0;
            change_q  <= '0;
            chv_q     <= 1'b0;
            vend_q    <= 1'b0;
            vid_q     <= '0;
            rej_q     <= 1'b0;
            timer_q   <= '0;
            for (int i = 0; i < 8; i++) begin
                stock_q[i] <= (i < N_PROD) ? QTY_W'(STOCK_INIT) : '0;
            end
        end else begin
            state_q   <= state_d;
            prod_q    <= prod_d;
            price_q   <= price_d;
            qty_q     <= qty_d;
            total_q   <= total_d;
            entered_q <= entered_d;
            change_q  <= change_d;
            chv_q     <= chv_d;
            vend_q    <= vend_d;
            vid_q     <= vid_d;
            rej_q     <= rej_d;
            timer_q   <= timer_d;
            stock_q   <= stock_d;
        end
    end

    assign bus.view_price     = price_q;
    assign bus.view_quantity  = qty_q;
    assign bus.view_price_q   = total_q;
    assign bus.entered_amount = entered_q;
    assign bus.change_amount  = change_q;
    assign bus.change_valid   = chv_q;
    assign bus.vend_pulse     = vend_q;
    assign bus.vend_id        = vid_q;
    assign bus.coin_reject    = rej_q;
    assign bus.state_o        = state_q;
endmodule

// File: tb/tb_vend_ctrl_param.sv
// Self-checking bench for vend_ctrl_param: keypad driver tasks, a monitor
// that pops expected vend/change/reject records, and directed scenarios.
module tb_vend_ctrl_param;
    localparam int N_PROD  = 5;
    localparam int PRICE_W = 8;
    localparam int QTY_W   = 4;
    localparam int AMT_W   = 13;
    localparam int TMO     = 200;

    logic clk;
    logic reset;

    vend_ctrl_param_if #(
        .N_PROD(N_PROD), .PRICE_W(PRICE_W), .QTY_W(QTY_W), .AMT_W(AMT_W)
    ) bus ();

    vend_ctrl_param #(
        .N_PROD(N_PROD), .PRICE_W(PRICE_W), .QTY_W(QTY_W), .AMT_W(AMT_W),
        .STOCK_INIT(5), .TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int n_total = 0;
    int n_bad   = 0;

    logic [15:0]      exp_vend_q[$];
    logic [AMT_W-1:0] exp_chg_q[$];
    logic [AMT_W-1:0] exp_rej_q[$];
    logic             prev_cv;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_hold(input int key, input int hold);
        @(posedge clk);
        #1;
        bus.c = ~(4'b0001 << (key / 4));
        bus.r = ~(4'b0001 << (key % 4));
        repeat (hold) @(posedge clk);
        #1;
        bus.c = 4'hF;
        bus.r = 4'hF;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic press(input int key);
        press_hold(key, 3);
    endtask

    task automatic press_n(input int key, input int n);
        for (int i = 0; i < n; i++) press(key);
    endtask

    // monitor: compare every DUT output event with the oldest expectation
    always @(negedge clk) begin
        if (!reset) begin
            prev_cv <= 1'b0;
        end else begin
            prev_cv <= bus.change_valid;
            if (bus.vend_pulse) begin
                check("vend_expected", exp_vend_q.size() != 0, 1);
                if (exp_vend_q.size() != 0)
                    check("vend_rec", {bus.vend_id, bus.view_price_q}, exp_vend_q.pop_front());
            end
            if (bus.change_valid && !prev_cv) begin
                check("change_expected", exp_chg_q.size() != 0, 1);
                if (exp_chg_q.size() != 0)
                    check("change_amount", bus.change_amount, exp_chg_q.pop_front());
            end
            if (bus.coin_reject) begin
                check("reject_expected", exp_rej_q.size() != 0, 1);
                if (exp_rej_q.size() != 0)
                    check("reject_entered", bus.entered_amount, exp_rej_q.pop_front());
            end
        end
    end

    initial begin
        reset           = 1'b0;
        bus.c           = 4'hF;
        bus.r           = 4'hF;
        bus.price_table = {8'd20, 8'd7, 8'd3, 8'd12, 8'd15};
        cycles(3);
        check("rst_state", bus.state_o, 0);
        check("rst_outputs", {bus.view_price, bus.view_quantity, bus.view_price_q,
                              bus.entered_amount, bus.change_valid, bus.vend_pulse,
                              bus.coin_reject}, 0);
        reset = 1'b1;
        cycles(2);

        // product 1, qty 2, exact payment 24
        press(15);
        check("t1_select", bus.state_o, 1);
        press(1);
        check("t1_qty_state", bus.state_o, 2);
        check("t1_price", bus.view_price, 12);
        check("t1_qty1", bus.view_quantity, 1);
        press(8);
        check("t1_qty2", bus.view_quantity, 2);
        press(10);
        check("t1_confirm", bus.state_o, 3);
        check("t1_total", bus.view_price_q, 24);
        press(10);
        check("t1_pay", bus.state_o, 4);
        exp_vend_q.push_back({3'd1, 13'd24});
        press(14);
        press(14);
        press(12);
        check("t1_entered22", bus.entered_amount, 22);
        press(12);
        check("t1_done", bus.state_o, 6);
        check("t1_no_change", bus.change_valid, 0);
        press(15);
        check("t1_idle", bus.state_o, 0);
        check("t1_view_clr", bus.view_price, 0);

        // stock of product 1 now 3: qty saturates there
        press(15);
        press(1);
        press_n(8, 10);
        check("stock1_left", bus.view_quantity, 3);
        press(11);
        press(11);
        check("back_idle", bus.state_o, 0);

        // qty saturation, held key, refund by cancel
        press(15);
        press(3);
        press_n(8, 10);
        check("qty_max", bus.view_quantity, 5);
        press_n(9, 10);
        check("qty_min", bus.view_quantity, 1);
        press_hold(8, 50);
        check("held_one_event", bus.view_quantity, 2);
        press(10);
        check("t3_total", bus.view_price_q, 14);
        press(10);
        press(13);
        press(12);
        check("t3_entered", bus.entered_amount, 7);
        exp_chg_q.push_back(13'd7);
        press(11);
        check("t3_refund_state", bus.state_o, 6);
        check("t3_refund_amt", bus.change_amount, 7);
        press(15);
        check("t3_take", bus.change_valid, 0);

        // overpay behaviour on product 0 (price 15)
        press(15);
        press(0);
        press(10);
        press(10);
        press(14);
        check("t2_entered10", bus.entered_amount, 10);
`ifdef VEND_CHANGE_EN
        exp_vend_q.push_back({3'd0, 13'd15});
        exp_chg_q.push_back(13'd5);
        press(14);
        check("t2_done", bus.state_o, 6);
        check("t2_change", bus.change_amount, 5);
`else
        exp_rej_q.push_back(13'd10);
        press(14);
        check("t2_reject_kept", bus.entered_amount, 10);
        exp_vend_q.push_back({3'd0, 13'd15});
        press(13);
        check("t2_done", bus.state_o, 6);
        check("t2_no_change", bus.change_valid, 0);
`endif
        press(15);
        check("t2_idle_cv", bus.change_valid, 0);

        // inactivity timeout in PAY with 2 entered
        press(15);
        press(4);
        press(10);
        press(10);
        press(12);
        check("tmo_entered", bus.entered_amount, 2);
        exp_chg_q.push_back(13'd2);
        for (int i = 0; i < 3 * TMO && bus.state_o != 3'd6; i++) @(posedge clk);
        #1;
        check("tmo_state", bus.state_o, 6);
        check("tmo_refund", bus.change_amount, 2);
        press(15);

        // buy all five of product 2, then it is sold out
        press(15);
        press(2);
        press_n(8, 4);
        check("t6_qty", bus.view_quantity, 5);
        press(10);
        check("t6_total", bus.view_price_q, 15);
        press(10);
        exp_vend_q.push_back({3'd2, 13'd15});
        press(14);
        press(13);
        check("t6_done", bus.state_o, 6);
        press(15);
        press(15);
        press(2);
        check("sold_out", bus.state_o, 1);
        @(posedge clk);
        #1;
        bus.c = 4'b1110;
        bus.r = 4'b1100;
        cycles(4);
        bus.c = 4'hF;
        bus.r = 4'hF;
        cycles(4);
        check("two_keys", bus.state_o, 1);
        press(11);

        // async reset while paying
        press(15);
        press(1);
        press(10);
        press(10);
        press(14);
        check("t7_entered", bus.entered_amount, 10);
        reset = 1'b0;
        #1;
        check("t7_rst_state", bus.state_o, 0);
        check("t7_rst_outputs", {bus.view_price, bus.view_quantity, bus.view_price_q,
                                 bus.entered_amount, bus.change_amount, bus.change_valid},
              0);
        cycles(2);
        reset = 1'b1;
        cycles(2);
        press(15);
        press(1);
        press_n(8, 10);
        check("t7_stock1", bus.view_quantity, 5);
        press(11);
        press(2);
        check("t7_stock2", bus.state_o, 2);
        press(11);
        press(11);

        cycles(5);
        check("vend_q_empty", exp_vend_q.size(), 0);
        check("chg_q_empty", exp_chg_q.size(), 0);
        check("rej_q_empty", exp_rej_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
